// File: rtl/hazard_stall_fwd_unit_pkg.sv
// Shared encodings for the D-stage hazard unit: Tuse/Tnew markers,
// forwarding select codes and default mult/div latencies.
package hazard_stall_fwd_unit_pkg;

  localparam int TW_DEF       = 2;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // Tnew/Tuse of 0 means "now"; the all-ones code means "never".
  localparam int T_NOW = 0;

  function automatic int t_never(input int tw);
    return (1 << tw) - 1;
  endfunction

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/hazard_stall_fwd_unit_md_busy_ctr.sv
// HI/LO occupancy counter: loads the mult/div latency when an operation
// leaves E and counts down; flags any start issued while still busy.
module md_busy_ctr
  import hazard_stall_fwd_unit_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic md_busy,
  output logic md_err
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;

  // A start while busy never reloads; the current operation keeps draining.
  always_comb begin
    cnt_next = cnt_reg;
    err_next = err_reg;
    if (start && cnt_reg == '0) begin
      cnt_next = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
    if (start && cnt_reg != '0) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end

  assign md_busy = (cnt_reg != '0);
  assign md_err  = err_reg;

endmodule

// File: rtl/hazard_stall_fwd_unit.sv
// D-stage hazard unit: Tuse/Tnew stall detection, D-stage forwarding
// selects and HI/LO busy tracking for the 5-stage MIPS pipeline.
module hazard_stall_fwd_unit
  import hazard_stall_fwd_unit_pkg::*;
#(
  parameter int RAW      = 5,
  parameter int TW       = TW_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int ALT_REG  = 31
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [RAW-1:0] D_rs,
  input  logic [RAW-1:0] D_rt,
  input  logic [TW-1:0]  D_tuse_rs,
  input  logic [TW-1:0]  D_tuse_rt,
  input  logic           D_md_use,
  input  logic [RAW-1:0] E_dst,
  input  logic           E_dst_alt,
  input  logic           E_we,
  input  logic [TW-1:0]  E_tnew,
  input  logic           E_md_start,
  input  logic           E_md_div,
  input  logic [RAW-1:0] M_dst,
  input  logic           M_we,
  input  logic [TW-1:0]  M_tnew,
  input  logic [RAW-1:0] W_dst,
  input  logic           W_we,
  output logic           stall,
  output logic [1:0]     fwd_rs,
  output logic [1:0]     fwd_rt,
  output logic           md_busy,
  output logic           md_err
);

  localparam logic [TW-1:0]  T_NEVER_V = TW'(t_never(TW));
  localparam logic [TW-1:0]  T_NOW_V   = TW'(T_NOW);
  localparam logic [RAW-1:0] ALT_V     = RAW'(ALT_REG);

  logic [RAW-1:0] src  [2];
  logic [TW-1:0]  tuse [2];
  logic [1:0]     src_stall;
  fwd_sel_e       fwd_sel [2];
  logic           md_hazard;

  assign src[0]  = D_rs;
  assign src[1]  = D_rt;
  assign tuse[0] = D_tuse_rs;
  assign tuse[1] = D_tuse_rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic     live;
      logic     hit_e, hit_m;
      fwd_sel_e sel;

      assign live  = (src[gi] != '0) && (tuse[gi] != T_NEVER_V);
      assign hit_e = live && E_we && (tuse[gi] < E_tnew) &&
                     ((src[gi] == E_dst) || (E_dst_alt && src[gi] == ALT_V));
      assign hit_m = live && M_we && (tuse[gi] < M_tnew) && (src[gi] == M_dst);

      // Youngest ready producer wins; an unresolved E destination cannot forward.
      always_comb begin
        sel = FWD_RF;
        if (!(hit_e || hit_m) && src[gi] != '0) begin
          if (E_we && !E_dst_alt && E_tnew == T_NOW_V && src[gi] == E_dst) begin
            sel = FWD_E;
          end else if (M_we && M_tnew == T_NOW_V && src[gi] == M_dst) begin
            sel = FWD_M;
          end else if (W_we && src[gi] == W_dst) begin
            sel = FWD_W;
          end
        end
      end

      assign src_stall[gi] = hit_e || hit_m;
      assign fwd_sel[gi]   = sel;
    end
  endgenerate

  md_busy_ctr #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_ctr (
    .clk     (clk),
    .reset   (reset),
    .start   (E_md_start),
    .is_div  (E_md_div),
    .md_busy (md_busy),
    .md_err  (md_err)
  );

  assign md_hazard = D_md_use && (md_busy || E_md_start);
  assign stall     = (|src_stall) || md_hazard;
  assign fwd_rs    = fwd_sel[0];
  assign fwd_rt    = fwd_sel[1];

endmodule
